// File: rtl/oled_arb_pkg.sv
// Shared types and encodings for the OLED character-channel arbiter.
package oled_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    GAP   = 3'd3,
    DRAIN = 3'd4
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT0     = 2'b01;
  localparam logic [1:0] GRANT1     = 2'b10;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } char_req_t;

  // After a message from the granted requester, priority passes to the other one.
  function automatic logic next_ptr(input logic [1:0] grant);
    return grant[0];
  endfunction

endpackage

// File: rtl/oled_rr_pick.sv
// Two-way round-robin picker: one-hot pick from valid, ties broken by rr_ptr.
module oled_rr_pick
  import oled_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  output logic [1:0] pick
);

  always_comb begin
    pick = GRANT_NONE;
    case (valid)
      2'b01:   pick = GRANT0;
      2'b10:   pick = GRANT1;
      2'b11:   pick = rr_ptr ? GRANT1 : GRANT0;
      default: pick = GRANT_NONE;
    endcase
  end

endmodule

// File: rtl/oled_char_arbiter.sv
// Message-granular round-robin arbiter in front of the oledControl character channel.
// Optional sendDone watchdog with DRAIN state is enabled by OLED_ARB_TIMEOUT_EN.
module oled_char_arbiter
  import oled_arb_pkg::*;
#(
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] sendData,
  output logic       sendDataValid,
  input  logic       sendDone,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  arb_state_e      state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [7:0]      data_q, data_d;
  logic            last_q, last_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [7:0]      gap_q, gap_d;

  logic [1:0]      req_valid;
  char_req_t [1:0] req;
  char_req_t       sel;
  logic            sel_valid;
  logic            take_phase;
  logic [1:0]      pick;
  logic            wd_hit;

  assign req_valid = {req1_valid, req0_valid};
  assign req[0]    = {req0_data, req0_last};
  assign req[1]    = {req1_data, req1_last};
  assign sel       = grant_q[1] ? req[1] : req[0];
  assign sel_valid = |(grant_q & req_valid);

  assign take_phase = (state_q == FETCH) || (state_q == DRAIN);
  assign req0_ready = take_phase & grant_q[0];
  assign req1_ready = take_phase & grant_q[1];

  assign sendData      = data_q;
  assign sendDataValid = (state_q == SEND);
  assign grant         = grant_q;
  assign busy          = (state_q != IDLE);

  oled_rr_pick u_pick (
    .valid  (req_valid),
    .rr_ptr (rr_ptr_q),
    .pick   (pick)
  );

`ifdef OLED_ARB_TIMEOUT_EN
  localparam logic [23:0] WD_LIMIT = 24'(TIMEOUT_CYCLES - 1);

  logic [23:0] wd_q;
  logic        err_q;

  assign wd_hit      = (state_q == SEND) && !sendDone && (wd_q == WD_LIMIT);
  assign timeout_err = err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= (state_q == SEND) ? wd_q + 24'd1 : 24'd0;
      if (wd_hit) err_q <= 1'b1;
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    data_d   = data_q;
    last_d   = last_q;
    rr_ptr_d = rr_ptr_q;
    gap_d    = gap_q;
    case (state_q)
      IDLE: begin
        if (pick != GRANT_NONE) begin
          grant_d = pick;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (sel_valid) begin
          data_d  = sel.data;
          last_d  = sel.last;
          state_d = SEND;
        end
      end
      SEND: begin
        if (sendDone) begin
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end else if (wd_hit) begin
          // A stuck final character has nothing left to drain.
          if (last_q) begin
            grant_d  = GRANT_NONE;
            rr_ptr_d = next_ptr(grant_q);
            state_d  = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q <= 8'd1) begin
          if (last_q) begin
            grant_d  = GRANT_NONE;
            rr_ptr_d = next_ptr(grant_q);
            state_d  = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      DRAIN: begin
        if (sel_valid && sel.last) begin
          grant_d  = GRANT_NONE;
          rr_ptr_d = next_ptr(grant_q);
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = GRANT_NONE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= GRANT_NONE;
      data_q   <= '0;
      last_q   <= 1'b0;
      rr_ptr_q <= 1'b0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      last_q   <= last_d;
      rr_ptr_q <= rr_ptr_d;
      gap_q    <= gap_d;
    end
  end

endmodule

// File: tb/tb_oled_char_arbiter.sv
// Directed bench for oled_char_arbiter: cycle vector table plus message-level sequences.
module tb_oled_char_arbiter;

  localparam int GAP    = 2;
  localparam int RENDER = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] sendData;
  logic       sendDataValid;
  logic       sendDone = 1'b0;
  logic [1:0] grant;
  logic       busy, timeout_err;

  always #5 clock = ~clock;

  oled_char_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .reset(reset),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .sendData(sendData), .sendDataValid(sendDataValid), .sendDone(sendDone),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic       v1;
    logic       done;
    logic [13:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [9:0] log_q[$];
  bit  auto_req = 0, auto_done = 0, en0 = 1, en1 = 1;
  int  rcnt = 0;

  function automatic logic [13:0] ev(logic [1:0] g, logic sv, logic [7:0] d,
                                     logic r0, logic r1, logic b);
    return {g, sv, d, r0, r1, b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    req0_valid = en0 && (q0.size() > 0);
    if (q0.size() > 0) {req0_data, req0_last} = q0[0];
    req1_valid = en1 && (q1.size() > 0);
    if (q1.size() > 0) {req1_data, req1_last} = q1[0];
  endtask

  // One clock: handshakes taken at the edge, then requesters and oledControl model update.
  task automatic step();
    logic a0, a1;
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    @(posedge clock); #1;
    if (auto_req) begin
      if (a0 && q0.size() > 0) q0.delete(0);
      if (a1 && q1.size() > 0) q1.delete(0);
      drive();
    end
    if (auto_done && sendDataValid) begin
      if (rcnt == RENDER) begin
        sendDone = 1'b1;
        log_q.push_back({grant, sendData});
        rcnt = 0;
      end else begin
        sendDone = 1'b0;
        rcnt++;
      end
    end else begin
      sendDone = 1'b0;
      rcnt = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sendDone = 1'b0;
    q0.delete(); q1.delete(); log_q.delete();
    en0 = 1; en1 = 1; rcnt = 0;
    drive();
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic run_until(input int n, input int budget, input string nm);
    int b = 0;
    while (log_q.size() < n && b < budget) begin
      step();
      b++;
    end
    if (log_q.size() < n) chk({nm, "_timeout"}, log_q.size(), n);
  endtask

  task automatic wait_idle(input string nm);
    int b = 0;
    while (busy && b < 100) begin
      step();
      b++;
    end
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic chk_log(input int idx, input logic [9:0] exp, input string nm);
    if (idx < log_q.size()) chk($sformatf("%s_%0d", nm, idx), log_q[idx], exp);
    else chk($sformatf("%s_%0d_missing", nm, idx), log_q.size(), idx + 1);
  endtask

  vec_t tv[14];

  initial begin
    // GAP=2, sendDone on the third SEND cycle, spurious sendDone in GAP and IDLE.
    tv[0]  = '{1'b1, 8'h48, 1'b0, 1'b0, 1'b0, ev(2'b00, 0, 8'h00, 0, 0, 0)};
    tv[1]  = '{1'b1, 8'h48, 1'b0, 1'b0, 1'b0, ev(2'b01, 0, 8'h00, 1, 0, 1)};
    tv[2]  = '{1'b1, 8'h49, 1'b1, 1'b0, 1'b0, ev(2'b01, 1, 8'h48, 0, 0, 1)};
    tv[3]  = '{1'b1, 8'h49, 1'b1, 1'b1, 1'b0, ev(2'b01, 1, 8'h48, 0, 0, 1)};
    tv[4]  = '{1'b1, 8'h49, 1'b1, 1'b1, 1'b1, ev(2'b01, 1, 8'h48, 0, 0, 1)};
    tv[5]  = '{1'b1, 8'h49, 1'b1, 1'b0, 1'b0, ev(2'b01, 0, 8'h48, 0, 0, 1)};
    tv[6]  = '{1'b1, 8'h49, 1'b1, 1'b0, 1'b1, ev(2'b01, 0, 8'h48, 0, 0, 1)};
    tv[7]  = '{1'b1, 8'h49, 1'b1, 1'b1, 1'b0, ev(2'b01, 0, 8'h48, 1, 0, 1)};
    tv[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ev(2'b01, 1, 8'h49, 0, 0, 1)};
    tv[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, ev(2'b01, 1, 8'h49, 0, 0, 1)};
    tv[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ev(2'b01, 0, 8'h49, 0, 0, 1)};
    tv[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ev(2'b01, 0, 8'h49, 0, 0, 1)};
    tv[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, ev(2'b00, 0, 8'h49, 0, 0, 0)};
    tv[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ev(2'b00, 0, 8'h49, 0, 0, 0)};

    #3;
    chk("reset_state", {grant, sendDataValid, sendData, req0_ready, req1_ready, busy, timeout_err},
        {ev(2'b00, 0, 8'h00, 0, 0, 0), 1'b0});
    do_reset();

    // Cycle-accurate "HI" from req0.
    for (int i = 0; i < 14; i++) begin
      req0_valid = tv[i].v0; req0_data = tv[i].d0; req0_last = tv[i].l0;
      req1_valid = tv[i].v1; req1_data = 8'h99;    req1_last = 1'b1;
      sendDone   = tv[i].done;
      #1;
      chk($sformatf("vec%0d", i), {grant, sendDataValid, sendData, req0_ready, req1_ready, busy},
          tv[i].exp);
      @(posedge clock); #1;
    end
    sendDone = 1'b0;
    auto_req = 1; auto_done = 1;

    // Simultaneous messages: req0 first, then req1; after a lone req0 message req1 wins the tie.
    do_reset();
    q0 = '{{8'h41, 1'b0}, {8'h42, 1'b0}, {8'h43, 1'b1}};
    q1 = '{{8'h61, 1'b0}, {8'h62, 1'b0}, {8'h63, 1'b1}};
    drive();
    run_until(6, 600, "rr1");
    chk_log(0, {2'b01, 8'h41}, "rr1"); chk_log(1, {2'b01, 8'h42}, "rr1");
    chk_log(2, {2'b01, 8'h43}, "rr1"); chk_log(3, {2'b10, 8'h61}, "rr1");
    chk_log(4, {2'b10, 8'h62}, "rr1"); chk_log(5, {2'b10, 8'h63}, "rr1");
    wait_idle("rr1");
    q0 = '{{8'h44, 1'b1}};
    drive();
    run_until(7, 200, "solo");
    chk_log(6, {2'b01, 8'h44}, "solo");
    wait_idle("solo");
    q0 = '{{8'h45, 1'b0}, {8'h46, 1'b1}};
    q1 = '{{8'h64, 1'b0}, {8'h65, 1'b1}};
    drive();
    run_until(11, 400, "rr2");
    chk_log(7, {2'b10, 8'h64}, "rr2"); chk_log(8, {2'b10, 8'h65}, "rr2");
    chk_log(9, {2'b01, 8'h45}, "rr2"); chk_log(10, {2'b01, 8'h46}, "rr2");
    wait_idle("rr2");

    // req1 stalls mid-message while req0 waits.
    do_reset();
    q1 = '{{8'h71, 1'b0}, {8'h72, 1'b0}, {8'h73, 1'b1}};
    drive();
    run_until(1, 100, "stall");
    en1 = 0;
    q0 = '{{8'h51, 1'b0}, {8'h52, 1'b1}};
    drive();
    begin
      int bad = 0;
      for (int i = 0; i < 50; i++) begin
        step();
        if (grant !== 2'b10 || req0_ready !== 1'b0 || (i > 5 && sendDataValid !== 1'b0)) bad++;
      end
      chk("stall_hold", bad, 0);
    end
    en1 = 1;
    drive();
    run_until(5, 400, "resume");
    chk_log(1, {2'b10, 8'h72}, "resume"); chk_log(2, {2'b10, 8'h73}, "resume");
    chk_log(3, {2'b01, 8'h51}, "resume"); chk_log(4, {2'b01, 8'h52}, "resume");
    wait_idle("resume");

    // Asynchronous reset during SEND.
    do_reset();
    q0 = '{{8'h81, 1'b0}, {8'h82, 1'b1}};
    drive();
    begin
      int b = 0;
      while (!sendDataValid && b < 20) begin step(); b++; end
      chk("pre_reset_send", sendDataValid, 1);
    end
    step(); step();
    #2 reset = 1'b0;
    #1;
    chk("async_reset", {grant, sendDataValid, sendData, req0_ready, req1_ready, busy, timeout_err},
        {ev(2'b00, 0, 8'h00, 0, 0, 0), 1'b0});
    q0.delete(); q1.delete(); log_q.delete(); rcnt = 0; sendDone = 1'b0;
    drive();
    @(posedge clock); #1;
    reset = 1'b1;
    q0 = '{{8'h4F, 1'b0}, {8'h4B, 1'b1}};
    drive();
    run_until(2, 200, "post_reset");
    chk_log(0, {2'b01, 8'h4F}, "post_reset"); chk_log(1, {2'b01, 8'h4B}, "post_reset");
    wait_idle("post_reset");

`ifdef OLED_ARB_TIMEOUT_EN
    // Watchdog: withheld sendDone, drain the rest of the message, then recover.
    do_reset();
    auto_done = 0;
    q0 = '{{8'h91, 1'b0}, {8'h92, 1'b0}, {8'h93, 1'b1}};
    drive();
    begin
      int b = 0;
      int cnt = 0;
      while (!sendDataValid && b < 20) begin step(); b++; end
      while (sendDataValid && cnt < 300) begin cnt++; step(); end
      chk("wd_send_cycles", cnt, 100);
      chk("wd_err_set", timeout_err, 1);
      b = 0;
      while (q0.size() > 0 && b < 20) begin step(); b++; end
      chk("wd_drained", q0.size(), 0);
      step(); step();
      chk("wd_idle", {busy, grant}, 3'b000);
      chk("wd_no_send", log_q.size(), 0);
    end
    auto_done = 1;
    q0 = '{{8'hA1, 1'b0}, {8'hA2, 1'b1}};
    drive();
    run_until(2, 200, "wd_next");
    chk_log(0, {2'b01, 8'hA1}, "wd_next"); chk_log(1, {2'b01, 8'hA2}, "wd_next");
    chk("wd_err_sticky", timeout_err, 1);
`else
    chk("timeout_err_tied", timeout_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
